// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master control block and the slave responder.
package spi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    localparam logic        SPI_CLOCK_IDLE = 1'b1;
    localparam logic [7:0]  FILL_BYTE      = 8'hFF;
    localparam int unsigned SPI_BYTE_W     = 8;
    localparam int unsigned WORD_BYTES     = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous pin, with single-cycle rise/fall pulses.
module sync_edge_detect #(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= {STAGES{RESET_LEVEL}};
            last_q <= RESET_LEVEL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~last_q;
    assign fall_o = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave: oversampled pins, MSB-first byte receive into a 32-bit word,
// one-deep transmit holding register with fill-byte substitution on underrun.
module spi_slave_responder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic        SPI_CLOCK_IDLE = spi_pkg::SPI_CLOCK_IDLE,
    parameter logic [7:0]  FILL_BYTE      = spi_pkg::FILL_BYTE
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        spi_clk_i,
    input  logic        spi_cs_n_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oe_o,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic        tx_underrun_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic [31:0] rx_word_o,
    output logic [2:0]  rx_bytes_valid_o,
    input  logic        rx_word_clear_i,
    output logic        frame_end_o,
    output logic        busy_o
);

    import spi_pkg::*;

    spi_state_e state_q, state_d;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic sample_edge, launch_edge;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    logic [2:0]            bit_cnt_q;
    logic [SPI_BYTE_W-1:0] tx_hold_q;
    logic                  tx_full_q;
    logic [SPI_BYTE_W-1:0] tx_shift_q;
    logic [SPI_BYTE_W-2:0] rx_shift_q;
    logic [SPI_BYTE_W-1:0] rx_byte;
    logic [SPI_BYTE_W-1:0] rx_data_q;
    logic [SPI_BYTE_W-1:0] load_byte;
    logic [31:0]           rx_word_q;
    logic [2:0]            fill_q;
    logic                  clear_pend_q;
    logic                  miso_q, miso_oe_q;
    logic                  rx_valid_q, underrun_q, frame_end_q;
    logic                  active, cs_leave, byte_done, word_restart;

    sync_edge_detect #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (SPI_CLOCK_IDLE)
    ) u_sclk_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (spi_clk_i),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    sync_edge_detect #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (1'b1)
    ) u_cs_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (spi_cs_n_i),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mosi_sync_q <= '1;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
        end
    end

    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sample_edge = SPI_CLOCK_IDLE ? sclk_rise : sclk_fall;
    assign launch_edge = SPI_CLOCK_IDLE ? sclk_fall : sclk_rise;

    assign active       = (state_q == ST_ACTIVE);
    // Chip-select release outranks any clock edge detected in the same cycle.
    assign cs_leave     = active && cs_rise;
    assign byte_done    = active && !cs_rise && sample_edge && (bit_cnt_q == 3'd7);
    assign rx_byte      = {rx_shift_q, mosi_s};
    assign word_restart = (fill_q == 3'(WORD_BYTES)) || rx_word_clear_i || clear_pend_q;
    assign load_byte    = tx_full_q ? tx_hold_q : FILL_BYTE;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == ST_ACTIVE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bit_cnt_q    <= '0;
            tx_hold_q    <= '0;
            tx_full_q    <= 1'b0;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_word_q    <= '0;
            fill_q       <= '0;
            clear_pend_q <= 1'b0;
            miso_q       <= 1'b1;
            miso_oe_q    <= 1'b0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            frame_end_q  <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_end_q <= 1'b0;

            if (tx_valid_i && !tx_full_q) begin
                tx_hold_q <= tx_data_i;
                tx_full_q <= 1'b1;
            end

            if (!active) begin
                if (cs_fall) begin
                    bit_cnt_q <= '0;
                    miso_oe_q <= 1'b1;
                    miso_q    <= 1'b1;
                end
            end else if (cs_leave) begin
                bit_cnt_q   <= '0;
                miso_oe_q   <= 1'b0;
                miso_q      <= 1'b1;
                frame_end_q <= 1'b1;
            end else begin
                if (launch_edge) begin
                    if (bit_cnt_q == 3'd0) begin
                        miso_q     <= load_byte[SPI_BYTE_W-1];
                        tx_shift_q <= {load_byte[SPI_BYTE_W-2:0], 1'b0};
                        if (tx_full_q) begin
                            tx_full_q <= 1'b0;
                        end else begin
                            underrun_q <= 1'b1;
                        end
                    end else begin
                        miso_q     <= tx_shift_q[SPI_BYTE_W-1];
                        tx_shift_q <= {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
                    end
                end
                if (sample_edge) begin
                    rx_shift_q <= {rx_shift_q[SPI_BYTE_W-3:0], mosi_s};
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                end
            end

            // A clear coinciding with a completed byte restarts the word with that byte.
            if (byte_done) begin
                rx_data_q    <= rx_byte;
                rx_valid_q   <= 1'b1;
                clear_pend_q <= 1'b0;
                if (word_restart) begin
                    rx_word_q <= {rx_byte, 24'h0};
                    fill_q    <= 3'd1;
                end else begin
                    unique case (fill_q[1:0])
                        2'd0:    rx_word_q[31:24] <= rx_byte;
                        2'd1:    rx_word_q[23:16] <= rx_byte;
                        2'd2:    rx_word_q[15:8]  <= rx_byte;
                        default: rx_word_q[7:0]   <= rx_byte;
                    endcase
                    fill_q <= fill_q + 3'd1;
                end
            end else if (rx_word_clear_i) begin
                clear_pend_q <= 1'b1;
                rx_word_q    <= '0;
                fill_q       <= '0;
            end
        end
    end

    assign spi_miso_o       = miso_q;
    assign spi_miso_oe_o    = miso_oe_q;
    assign tx_ready_o       = ~tx_full_q;
    assign tx_underrun_o    = underrun_q;
    assign rx_data_o        = rx_data_q;
    assign rx_valid_o       = rx_valid_q;
    assign rx_word_o        = rx_word_q;
    assign rx_bytes_valid_o = fill_q;
    assign frame_end_o      = frame_end_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed and randomized SPI master stimulus against a word-assembly / tx-queue reference model.
module tb_spi_slave_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        spi_sclk, spi_cs_n, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_underrun;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] rx_word;
    logic [2:0]  rx_bytes_valid;
    logic        rx_word_clear;
    logic        frame_end, busy;

    int errors = 0;
    int checks = 0;
    int rxv_cnt = 0, und_cnt = 0, fe_cnt = 0;
    int rxv0, und0, fe0;
    logic        ready_at_bit0;
    logic [31:0] m_word;
    int          m_fill;

    always #5 clk = ~clk;

    spi_slave_responder #(
        .SYNC_STAGES    (2),
        .SPI_CLOCK_IDLE (1'b1),
        .FILL_BYTE      (8'hFF)
    ) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .spi_clk_i        (spi_sclk),
        .spi_cs_n_i       (spi_cs_n),
        .spi_mosi_i       (spi_mosi),
        .spi_miso_o       (spi_miso),
        .spi_miso_oe_o    (spi_miso_oe),
        .tx_data_i        (tx_data),
        .tx_valid_i       (tx_valid),
        .tx_ready_o       (tx_ready),
        .tx_underrun_o    (tx_underrun),
        .rx_data_o        (rx_data),
        .rx_valid_o       (rx_valid),
        .rx_word_o        (rx_word),
        .rx_bytes_valid_o (rx_bytes_valid),
        .rx_word_clear_i  (rx_word_clear),
        .frame_end_o      (frame_end),
        .busy_o           (busy)
    );

    always @(negedge clk) begin
        if (rx_valid)    rxv_cnt++;
        if (tx_underrun) und_cnt++;
        if (frame_end)   fe_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        rxv0 = rxv_cnt;
        und0 = und_cnt;
        fe0  = fe_cnt;
    endtask

    // Word assembly rule: bytes fill from the top; a fifth byte starts a fresh word.
    task automatic model_byte(input logic [7:0] b);
        logic [31:0] bw;
        bw = {24'h0, b};
        if (m_fill == 4) begin
            m_word = bw << 24;
            m_fill = 1;
        end else begin
            m_word = m_word | (bw << (8 * (3 - m_fill)));
            m_fill = m_fill + 1;
        end
    endtask

    task automatic model_clear();
        m_word = '0;
        m_fill = 0;
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit clr_last,
                            output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_sclk = 1'b0;
            spi_mosi = mo[i];
            wait_clk(HALF);
            if (i == 7) ready_at_bit0 = tx_ready;
            spi_sclk = 1'b1;
            mi[i] = spi_miso;
            if (clr_last && i == 0) begin
                wait_clk(2);
                rx_word_clear = 1'b1;
                wait_clk(1);
                rx_word_clear = 1'b0;
                wait_clk(HALF - 3);
            end else begin
                wait_clk(HALF);
            end
        end
    endtask

    task automatic frame_begin();
        spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_finish();
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic clear_idle();
        rx_word_clear = 1'b1;
        wait_clk(1);
        rx_word_clear = 1'b0;
        model_clear();
        check("clear_word", rx_word, 32'h0);
        check("clear_fill", {29'h0, rx_bytes_valid}, 32'd0);
    endtask

    task automatic tx_write(input logic [7:0] b);
        int t;
        t = 0;
        while (!tx_ready && t < 50) begin
            wait_clk(1);
            t++;
        end
        check("tx_ready_before_write", {31'h0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        check("tx_ready_after_write", {31'h0, tx_ready}, 32'd0);
    endtask

    task automatic send_checked(input logic [7:0] mo, input logic [7:0] exp_miso, input string tag);
        logic [7:0] mi;
        spi_bits(mo, 8, 1'b0, mi);
        model_byte(mo);
        check({tag, "_miso"}, {24'h0, mi}, {24'h0, exp_miso});
        check({tag, "_rx_data"}, {24'h0, rx_data}, {24'h0, mo});
        check({tag, "_word"}, rx_word, m_word);
        check({tag, "_fill"}, {29'h0, rx_bytes_valid}, m_fill);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},     {31'h0, spi_miso}, 32'd1);
        check({tag, "_miso_oe"},  {31'h0, spi_miso_oe}, 32'd0);
        check({tag, "_tx_ready"}, {31'h0, tx_ready}, 32'd1);
        check({tag, "_rx_data"},  {24'h0, rx_data}, 32'h0);
        check({tag, "_rx_word"},  rx_word, 32'h0);
        check({tag, "_fill"},     {29'h0, rx_bytes_valid}, 32'd0);
        check({tag, "_pulses"},   {29'h0, rx_valid, tx_underrun, frame_end}, 32'd0);
        check({tag, "_busy"},     {31'h0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] mi, b1, b2, b3, tb_byte;
        int nb, und_exp;

        rstn = 1'b0;
        spi_sclk = 1'b1;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b1;
        tx_data = '0;
        tx_valid = 1'b0;
        rx_word_clear = 1'b0;
        model_clear();
        wait_clk(3);
        check_reset_outputs("reset");
        rstn = 1'b1;
        wait_clk(2);

        // Single byte with preloaded tx data
        tx_write(8'h3C);
        snap();
        frame_begin();
        check("busy_active", {31'h0, busy}, 32'd1);
        check("miso_oe_active", {31'h0, spi_miso_oe}, 32'd1);
        spi_bits(8'hA5, 8, 1'b0, mi);
        model_byte(8'hA5);
        check("t1_miso", {24'h0, mi}, 32'h3C);
        check("t1_ready_after_load", {31'h0, ready_at_bit0}, 32'd1);
        check("t1_rx_data", {24'h0, rx_data}, 32'hA5);
        check("t1_word", rx_word, 32'hA500_0000);
        frame_finish();
        check("t1_rx_valid_count", rxv_cnt - rxv0, 1);
        check("t1_underrun_count", und_cnt - und0, 0);
        check("t1_frame_end_count", fe_cnt - fe0, 1);
        check("t1_busy_idle", {31'h0, busy}, 32'd0);
        check("t1_miso_oe_idle", {31'h0, spi_miso_oe}, 32'd0);

        // Five bytes in one frame, word wrap
        clear_idle();
        snap();
        frame_begin();
        for (int k = 0; k < 5; k++) begin
            b1 = 8'h11 * (k + 1);
            send_checked(b1, 8'hFF, "t2");
            if (k == 3) begin
                check("t2_word_full", rx_word, 32'h1122_3344);
                check("t2_fill_full", {29'h0, rx_bytes_valid}, 32'd4);
            end
        end
        check("t2_word_wrap", rx_word, 32'h5500_0000);
        check("t2_fill_wrap", {29'h0, rx_bytes_valid}, 32'd1);
        frame_finish();
        check("t2_rx_valid_count", rxv_cnt - rxv0, 5);
        check("t2_underrun_count", und_cnt - und0, 5);

        // Two bytes with no tx data
        snap();
        frame_begin();
        send_checked(8'($urandom), 8'hFF, "t3a");
        send_checked(8'($urandom), 8'hFF, "t3b");
        frame_finish();
        check("t3_underrun_count", und_cnt - und0, 2);

        // Frame aborted after 3 bits of second byte
        clear_idle();
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        snap();
        frame_begin();
        send_checked(b1, 8'hFF, "t4a");
        spi_bits(b2, 3, 1'b0, mi);
        frame_finish();
        check("t4_frame_end_count", fe_cnt - fe0, 1);
        check("t4_rx_valid_count", rxv_cnt - rxv0, 1);
        check("t4_fill_retained", {29'h0, rx_bytes_valid}, 32'd1);
        check("t4_rx_data_kept", {24'h0, rx_data}, {24'h0, b1});
        b3 = 8'($urandom);
        frame_begin();
        send_checked(b3, 8'hFF, "t4b");
        check("t4_second_slot", rx_word, {b1, b3, 16'h0});
        frame_finish();

        // Clear coincides with third byte completion
        clear_idle();
        frame_begin();
        send_checked(8'($urandom), 8'hFF, "t5a");
        send_checked(8'($urandom), 8'hFF, "t5b");
        b3 = 8'($urandom);
        spi_bits(b3, 8, 1'b1, mi);
        check("t5_word", rx_word, {b3, 24'h0});
        check("t5_fill", {29'h0, rx_bytes_valid}, 32'd1);
        frame_finish();
        model_clear();
        model_byte(b3);

        // cs rising and sclk rising seen together: no byte completes
        clear_idle();
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        snap();
        frame_begin();
        send_checked(b1, 8'hFF, "t6a");
        spi_bits(b2, 7, 1'b0, mi);
        spi_sclk = 1'b0;
        spi_mosi = b2[0];
        wait_clk(HALF);
        spi_sclk = 1'b1;
        spi_cs_n = 1'b1;
        wait_clk(2 * HALF);
        check("t6_rx_valid_count", rxv_cnt - rxv0, 1);
        check("t6_frame_end_count", fe_cnt - fe0, 1);
        check("t6_fill", {29'h0, rx_bytes_valid}, 32'd1);
        check("t6_rx_data", {24'h0, rx_data}, {24'h0, b1});

        // sclk toggling while deselected
        snap();
        for (int k = 0; k < 4; k++) begin
            spi_sclk = 1'b0;
            wait_clk(HALF);
            spi_sclk = 1'b1;
            wait_clk(HALF);
        end
        check("idle_sclk_rx_valid", rxv_cnt - rxv0, 0);
        check("idle_sclk_busy", {31'h0, busy}, 32'd0);

        // Asynchronous reset mid-byte
        tx_write(8'($urandom));
        frame_begin();
        spi_bits(8'($urandom), 4, 1'b0, mi);
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        spi_sclk = 1'b1;
        spi_cs_n = 1'b1;
        wait_clk(2);
        rstn = 1'b1;
        wait_clk(2);
        model_clear();
        frame_begin();
        send_checked(8'($urandom), 8'hFF, "t7");
        frame_finish();

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 1) == 1) clear_idle();
            nb = $urandom_range(1, 6);
            und_exp = 0;
            snap();
            frame_begin();
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    tb_byte = 8'($urandom);
                    tx_write(tb_byte);
                end else begin
                    tb_byte = 8'hFF;
                    und_exp++;
                end
                send_checked(8'($urandom), tb_byte, "rand");
            end
            frame_finish();
            check("rand_rx_valid_count", rxv_cnt - rxv0, nb);
            check("rand_underrun_count", und_cnt - und0, und_exp);
            check("rand_frame_end_count", fe_cnt - fe0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI responder (slave) for the far end of the team's SPI master control block; sits in the peripheral/test-target fabric on the system clock domain.
- Oversamples the incoming SPI clock, chip-select and MOSI. Shifts received bytes MSB-first into a 32-bit word assembly register. Serves transmit bytes from a one-deep holding register onto MISO.
- Mode fixed to match the master: clock idles high, data changes on the falling edge and is sampled on the rising edge, MSB first. Idle fill byte is 0xFF.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchroniser (minimum 2).
- SPI_CLOCK_IDLE, 1, idle level of spi_clk_i; the sampling edge is the transition away from the non-idle level.
- FILL_BYTE, 8'hFF, byte shifted out when no transmit data is held.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- spi_clk_i  in  1  SPI clock from master, asynchronous.
- spi_cs_n_i  in  1  chip select, active low, asynchronous.
- spi_mosi_i  in  1  master-out data, asynchronous.
- spi_miso_o  out  1  slave-out data.
- spi_miso_oe_o  out  1  MISO output enable; high only while selected.
- tx_data_i  in  8  next byte to transmit.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  holding register empty.
- tx_underrun_o  out  1  one-cycle pulse when FILL_BYTE is substituted.
- rx_data_o  out  8  last complete received byte.
- rx_valid_o  out  1  one-cycle pulse per received byte.
- rx_word_o  out  32  assembled word; first byte lands in [31:24].
- rx_bytes_valid_o  out  3  bytes valid in rx_word_o, 0..4.
- rx_word_clear_i  in  1  pulse that restarts word assembly.
- frame_end_o  out  1  one-cycle pulse on chip-select deassertion.
- busy_o  out  1  high in ACTIVE state.

Behaviour:
- Reset values:
  - spi_miso_o=1; spi_miso_oe_o=0; tx_ready_o=1.
  - rx_data_o=0; rx_word_o=0; rx_bytes_valid_o=0.
  - All pulse outputs 0; busy_o=0; state IDLE; bit_cnt=0.
  - Synchroniser flops reset to their idle levels (sclk=SPI_CLOCK_IDLE, cs_n=1, mosi=1).
- Synchronisation and edge detection:
  - All three pins pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchroniser stage with one extra registered copy.
  - Effect latency is SYNC_STAGES+1 clk_i cycles from the pin edge.
  - Requirement on the master: SPI clock half-period of at least SYNC_STAGES+2 clk_i cycles.
- TX holding register:
  - A write occurs when tx_valid_i and tx_ready_o are both high; tx_ready_o then drops on the next cycle.
  - Writes are accepted in either state.
- State machine, IDLE to ACTIVE:
  - Transition on synchronised cs_n falling.
  - On entry: bit_cnt=0; spi_miso_oe_o=1; spi_miso_o=1.
- ACTIVE, on each synchronised sclk falling edge:
  - If bit_cnt==0: load the shifter from the holding register and set tx_ready_o=1. If the holding register is empty, load FILL_BYTE and pulse tx_underrun_o. Drive the MSB on spi_miso_o.
  - Otherwise: shift the next bit out.
- ACTIVE, on each synchronised sclk rising edge:
  - Shift mosi into rx_shift LSB-side and increment bit_cnt.
  - When bit_cnt wraps 7 to 0:
    - rx_data_o takes the completed byte; pulse rx_valid_o.
    - Word write: byte goes to rx_word_o[8*(3-fill)+:8], then fill=fill+1.
    - If fill was 4, or rx_word_clear_i is asserted this cycle (or pending), the word resets to {byte,24'h0} and fill=1.
- rx_word_clear_i handling:
  - Pulse in IDLE, or mid-byte: latched pending; rx_word_o/rx_bytes_valid_o are cleared to 0 immediately.
  - Pulse in the same cycle as a byte completion: the result is the new byte alone, fill=1.
- ACTIVE to IDLE:
  - Transition on synchronised cs_n rising at any point.
  - A partial rx byte is discarded; bit_cnt=0; spi_miso_oe_o=0; spi_miso_o=1; pulse frame_end_o.
  - rx_word_o/rx_bytes_valid_o are retained.
  - An unsent shifter byte is dropped; the holding register is untouched.
- Simultaneous cs_n rising and sclk rising detected in the same cycle: cs_n wins and no byte is completed.
- sclk edges in IDLE are ignored.
- Asynchronous reset mid-frame returns every register to its reset value immediately.

Decomposition:
- Shared package spi_pkg:
  - state encoding (IDLE, ACTIVE)
  - SPI_CLOCK_IDLE, FILL_BYTE and SPI byte-width constants
  - word byte count (4), shared with the master control block.
- One sub-module, sync_edge_detect:
  - parameterised synchroniser plus rise/fall pulse outputs and reset level.
  - Instantiated for sclk and cs_n; mosi uses the synchroniser output only.

Test Plan:
- Reset, then cs_n low and one byte 0xA5 from master with tx_data 0x3C preloaded -> rx_data_o=0xA5, one rx_valid_o pulse; MISO bits 0,0,1,1,1,1,0,0; tx_ready_o re-high after first falling edge.
- Five bytes 11,22,33,44,55 in one frame -> rx_word_o=0x11223344 with bytes_valid=4; then 0x55000000 with bytes_valid=1.
- No tx data written, two bytes clocked -> MISO all ones, two tx_underrun_o pulses.
- cs_n deasserted after 3 bits of the second byte -> frame_end_o pulse, no second rx_valid_o, rx_bytes_valid_o stays 1, next frame's first byte lands in [23:16].
- rx_word_clear_i pulsed in the same cycle as the 3rd byte completion -> rx_word_o={byte3,24'h0}, rx_bytes_valid_o=1.
- rstn_i asserted mid-byte -> all outputs at reset values immediately; a fresh frame afterwards receives correctly.
